// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and constants for the bit-serial adder controller.
//   - state_t       : controller state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default operand/result width in bits
// ---------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/fa_bit.sv
// ---------------------------------------------------------------------------
// fa_bit
//   Combinational single-bit full adder. This is the shared cell that the
//   serial controller reuses once per clock for every bit position.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
// ---------------------------------------------------------------------------
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : fa_bit

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller: adds two WIDTH-bit operands one bit per
//   clock, LSB first, through a single fa_bit cell, with the carry held in a
//   flip-flop between bits. Latency start->done is WIDTH+1 cycles.
//
//   Build option:
//     SERIAL_ADD_SUB_EN - adds the 'sub' input; sub=1 computes a - b as
//                         a + ~b + 1 (cin ignored). Undefined: add only.
//
//   Ports:
//     clk, rst_n : rising-edge clock, asynchronous active-low reset
//     start      : request pulse, accepted only in IDLE
//     a, b, cin  : operands and carry-in, sampled on the accepting edge
//     sub        : subtract request (SERIAL_ADD_SUB_EN only)
//     busy       : high whenever the controller is not IDLE
//     done       : one-cycle completion pulse
//     sum        : result, held until the next completion
//     cout       : carry out of the MSB (in subtract mode 1 = no borrow)
//     overflow   : signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_ps;      // partial sum, filled from the MSB end
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_sb_load;
    logic               w_carry_load;
    logic               w_s;
    logic               w_co;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1: invert B and force the initial carry.
    assign w_sb_load    = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : cin;
`else
    assign w_sb_load    = b;
    assign w_carry_load = cin;
`endif

    fa_bit u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    // NOTE: every register, including the operand shift registers, is
    // cleared on reset so an aborted operation leaves no residue behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_ps    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below
            // sees the value from before this edge.
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= w_sb_load;
                        r_carry <= w_carry_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_ps    <= {w_s, r_ps[WIDTH-1:1]};
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        // On the MSB, r_carry is the carry into the MSB, so
                        // overflow is available without a separate latch.
                        r_sum   <= {w_s, r_ps[WIDTH-1:1]};
                        r_cout  <= w_co;
                        r_ovf   <= r_carry ^ w_co;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule : serial_add_ctrl
